// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - byte-wide RAM/IO port sequencer for ICache/DCache line bursts and IO transfers (option macro: MEM_CTRL_ROUND_ROBIN_EN)
module mem_controller #(
  parameter  int BLOCK_WIDTH = 4,
  localparam int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
  input  logic                      clkIn,
  input  logic                      resetIn,
  input  logic                      clearIn,
  input  logic                      iMiss,
  input  logic [31:BLOCK_WIDTH]     iMissAddr,
  output logic                      iDataValid,
  output logic [BLOCK_SIZE*8-1:0]   iDataOut,
  input  logic                      dMiss,
  input  logic                      dReadWrite,
  input  logic [31:BLOCK_WIDTH]     dMissAddr,
  input  logic [BLOCK_SIZE*8-1:0]   dWriteData,
  output logic                      memDataValid,
  output logic [31:BLOCK_WIDTH]     memAddr,
  output logic [BLOCK_SIZE*8-1:0]   memDataOut,
  output logic                      acceptWrite,
  input  logic                      ioValid,
  input  logic                      ioReadWrite,
  input  logic [1:0]                ioType,
  input  logic [31:0]               ioAddr,
  input  logic [31:0]               ioData,
  output logic                      mutableMemInValid,
  output logic [31:0]               mutableMemDataOut,
  output logic                      mutableWriteSuc,
  input  logic [7:0]                memIn,
  output logic [7:0]                memOut,
  output logic [31:0]               memA,
  output logic                      memWr,
  input  logic                      ioBufferFull
);

  localparam int LINE_BITS = BLOCK_SIZE * 8;
  localparam int CW        = BLOCK_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_IREAD, S_DREAD, S_DWRITE, S_IOREAD, S_IOWRITE, S_DONE
  } state_t;

  state_t               r_state;
  state_t               r_kind;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_len;
  logic [31:0]          r_base;
  logic [LINE_BITS-1:0] r_buf;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
  logic                 r_rr_ifirst;
`endif

  logic                   w_dw_req;
  logic                   w_dr_req;
  logic                   w_grant_d;
  logic                   w_grant_i;
  logic [CW-1:0]          w_io_len;
  logic [BLOCK_WIDTH-1:0] w_cap_idx;
  logic                   w_wr_go;
  logic                   w_done;

  assign w_dw_req  = dMiss && !dReadWrite;
  assign w_dr_req  = dMiss && dReadWrite;
  // Byte captured this cycle is the one addressed in the previous cycle.
  assign w_cap_idx = r_cnt[BLOCK_WIDTH-1:0] - BLOCK_WIDTH'(1);
  // Only the IO write path may be stalled by the downstream write buffer.
  assign w_wr_go   = !(r_state == S_IOWRITE && ioBufferFull);
  assign w_done    = (r_state == S_DONE);

  // Transfer length for IO accesses; an undefined size code moves one byte.
  always_comb begin
    w_io_len = CW'(1);
    case (ioType)
      2'b10:   w_io_len = CW'(2);
      2'b11:   w_io_len = CW'(4);
      default: w_io_len = CW'(1);
    endcase
  end

  // Choose between a DCache line read and an ICache line read.
  always_comb begin
`ifdef MEM_CTRL_ROUND_ROBIN_EN
    w_grant_i = iMiss && (!w_dr_req || r_rr_ifirst);
    w_grant_d = w_dr_req && !w_grant_i;
`else
    w_grant_d = w_dr_req;
    w_grant_i = iMiss && !w_dr_req;
`endif
  end

  // Main sequencer: arbitration, byte counting, read capture and completion.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      r_state <= S_IDLE;
      r_kind  <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_base  <= '0;
      r_buf   <= '0;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
      r_rr_ifirst <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_dw_req) begin
            r_state <= S_DWRITE;
            r_kind  <= S_DWRITE;
            r_base  <= {dMissAddr, {BLOCK_WIDTH{1'b0}}};
            r_len   <= CW'(BLOCK_SIZE);
            r_buf   <= dWriteData;
          end else if (ioValid) begin
            r_base <= ioAddr;
            r_len  <= w_io_len;
            if (ioReadWrite) begin
              r_state <= S_IOREAD;
              r_kind  <= S_IOREAD;
              r_buf   <= '0;
            end else begin
              r_state <= S_IOWRITE;
              r_kind  <= S_IOWRITE;
              r_buf   <= {{(LINE_BITS-32){1'b0}}, ioData};
            end
          end else if (w_grant_d) begin
            r_state <= S_DREAD;
            r_kind  <= S_DREAD;
            r_base  <= {dMissAddr, {BLOCK_WIDTH{1'b0}}};
            r_len   <= CW'(BLOCK_SIZE);
            r_buf   <= '0;
          end else if (w_grant_i) begin
            r_state <= S_IREAD;
            r_kind  <= S_IREAD;
            r_base  <= {iMissAddr, {BLOCK_WIDTH{1'b0}}};
            r_len   <= CW'(BLOCK_SIZE);
            r_buf   <= '0;
          end
`ifdef MEM_CTRL_ROUND_ROBIN_EN
          if (!w_dw_req && !ioValid && w_dr_req && iMiss) begin
            r_rr_ifirst <= !r_rr_ifirst;
          end
`endif
        end
        S_IREAD, S_DREAD, S_IOREAD: begin
          if (clearIn) begin
            r_state <= S_IDLE;
          end else begin
            if (r_cnt != '0) begin
              r_buf[{w_cap_idx, 3'b000} +: 8] <= memIn;
            end
            if (r_cnt == r_len) begin
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_DWRITE, S_IOWRITE: begin
          if (w_wr_go) begin
            if (r_cnt == r_len - CW'(1)) begin
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory pin drive: idle and completion cycles keep the port quiet.
  always_comb begin
    memA   = 32'd0;
    memWr  = 1'b0;
    memOut = 8'd0;
    case (r_state)
      S_IREAD, S_DREAD, S_IOREAD: begin
        memA = r_base + 32'(r_cnt);
      end
      S_DWRITE, S_IOWRITE: begin
        memA   = r_base + 32'(r_cnt);
        memWr  = w_wr_go;
        memOut = r_buf[{r_cnt[BLOCK_WIDTH-1:0], 3'b000} +: 8];
      end
      default: begin
        memA   = 32'd0;
        memWr  = 1'b0;
        memOut = 8'd0;
      end
    endcase
  end

  // A flush in the completion cycle of a read suppresses its pulse.
  assign iDataValid        = w_done && (r_kind == S_IREAD)   && !clearIn;
  assign memDataValid      = w_done && (r_kind == S_DREAD)   && !clearIn;
  assign mutableMemInValid = w_done && (r_kind == S_IOREAD)  && !clearIn;
  assign acceptWrite       = w_done && (r_kind == S_DWRITE);
  assign mutableWriteSuc   = w_done && (r_kind == S_IOWRITE);

  assign iDataOut          = r_buf;
  assign memDataOut        = r_buf;
  assign mutableMemDataOut = r_buf[31:0];
  assign memAddr           = r_base[31:BLOCK_WIDTH];

endmodule

// File: tb/tb_mem_controller.sv
// tb/tb_mem_controller.sv - directed self-checking bench for mem_controller
module tb_mem_controller;

  localparam int BW = 4;

  logic          clkIn = 1'b0;
  logic          resetIn = 1'b0;
  logic          clearIn = 1'b0;
  logic          iMiss = 1'b0;
  logic [31:BW]  iMissAddr = '0;
  logic          iDataValid;
  logic [127:0]  iDataOut;
  logic          dMiss = 1'b0;
  logic          dReadWrite = 1'b0;
  logic [31:BW]  dMissAddr = '0;
  logic [127:0]  dWriteData = '0;
  logic          memDataValid;
  logic [31:BW]  memAddr;
  logic [127:0]  memDataOut;
  logic          acceptWrite;
  logic          ioValid = 1'b0;
  logic          ioReadWrite = 1'b0;
  logic [1:0]    ioType = 2'b01;
  logic [31:0]   ioAddr = '0;
  logic [31:0]   ioData = '0;
  logic          mutableMemInValid;
  logic [31:0]   mutableMemDataOut;
  logic          mutableWriteSuc;
  logic [7:0]    memIn = 8'd0;
  logic [7:0]    memOut;
  logic [31:0]   memA;
  logic          memWr;
  logic          ioBufferFull = 1'b0;

  mem_controller #(.BLOCK_WIDTH(BW)) dut (
    .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearIn),
    .iMiss(iMiss), .iMissAddr(iMissAddr), .iDataValid(iDataValid), .iDataOut(iDataOut),
    .dMiss(dMiss), .dReadWrite(dReadWrite), .dMissAddr(dMissAddr), .dWriteData(dWriteData),
    .memDataValid(memDataValid), .memAddr(memAddr), .memDataOut(memDataOut), .acceptWrite(acceptWrite),
    .ioValid(ioValid), .ioReadWrite(ioReadWrite), .ioType(ioType), .ioAddr(ioAddr), .ioData(ioData),
    .mutableMemInValid(mutableMemInValid), .mutableMemDataOut(mutableMemDataOut),
    .mutableWriteSuc(mutableWriteSuc), .memIn(memIn), .memOut(memOut), .memA(memA),
    .memWr(memWr), .ioBufferFull(ioBufferFull)
  );

  always #5 clkIn = ~clkIn;

  int cyc = 0;
  always @(posedge clkIn) cyc <= cyc + 1;

  // RAM/IO space: byte k holds k[7:0] until written; one-cycle read latency.
  logic [7:0] ram [0:(1<<18)-1];
  initial for (int k = 0; k < (1 << 18); k++) ram[k] = k[7:0];
  always @(posedge clkIn) begin
    memIn <= ram[memA[17:0]];
    if (memWr) ram[memA[17:0]] <= memOut;
  end

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Expected per-cycle behaviour, keyed by cycle number.
  bit           exp_wr    [int];
  logic [31:0]  exp_a     [int];
  logic [7:0]   exp_out   [int];
  logic [4:0]   exp_pulse [int];
  logic [127:0] exp_data  [int];
  logic [27:0]  exp_maddr [int];
  logic [4:0]   lit_pulse [int];
  logic [127:0] lit_data  [int];
  logic [31:0]  lit_a     [int];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clkIn);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  // Line read: addresses in burst cycles 0..15, pulse in burst cycle 17.
  task automatic plan_line_read(input int g, input logic [31:0] base, input bit icache);
    logic [127:0] d;
    d = '0;
    for (int k = 0; k < 16; k++) begin
      exp_a[g+1+k]  = base + k;
      exp_wr[g+1+k] = 1'b0;
      d[8*k +: 8]   = ram[base[17:0] + k];
    end
    exp_pulse[g+18] = icache ? 5'b10000 : 5'b01000;
    exp_data[g+18]  = d;
    exp_maddr[g+18] = base[31:4];
  endtask

  // Line write: bytes in burst cycles 0..upto-1, acceptWrite in burst cycle 16.
  task automatic plan_line_write(input int g, input logic [31:0] base, input logic [127:0] line,
                                 input int upto, input bit pulse);
    for (int k = 0; k < upto; k++) begin
      exp_wr[g+1+k]  = 1'b1;
      exp_a[g+1+k]   = base + k;
      exp_out[g+1+k] = line[8*k +: 8];
    end
    if (pulse) begin
      exp_pulse[g+17] = 5'b00100;
      exp_maddr[g+17] = base[31:4];
    end
  endtask

  // IO transfer; a set bit c in stall marks burst cycle c as buffer-full.
  task automatic plan_io(input int g, input bit rd, input logic [1:0] ty, input logic [31:0] a,
                         input logic [31:0] d, input int stall, output int p);
    int n;
    int c;
    int b;
    logic [127:0] rdv;
    n = (ty == 2'b11) ? 4 : (ty == 2'b10) ? 2 : 1;
    rdv = '0;
    if (rd) begin
      for (int k = 0; k < n; k++) begin
        exp_a[g+1+k]  = a + k;
        exp_wr[g+1+k] = 1'b0;
        rdv[8*k +: 8] = ram[a[17:0] + k];
      end
      p = g + n + 2;
      exp_pulse[p] = 5'b00010;
      exp_data[p]  = rdv;
    end else begin
      c = 0;
      b = 0;
      while (b < n) begin
        if (((stall >> c) & 1) != 0) begin
          exp_wr[g+1+c] = 1'b0;
        end else begin
          exp_wr[g+1+c]  = 1'b1;
          exp_a[g+1+c]   = a + b;
          exp_out[g+1+c] = d[8*b +: 8];
          b++;
        end
        c++;
      end
      p = g + 1 + c;
      exp_pulse[p] = 5'b00001;
    end
  endtask

  task automatic do_io(input bit rd, input logic [1:0] ty, input logic [31:0] a,
                       input logic [31:0] d, input int stall);
    int g;
    int p;
    g = cyc;
    ioValid = 1'b1; ioReadWrite = rd; ioType = ty; ioAddr = a; ioData = d;
    plan_io(g, rd, ty, a, d, stall, p);
    step();
    ioValid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      ioBufferFull = ((stall >> c) & 1) != 0;
      step();
    end
    ioBufferFull = 1'b0;
    wait_cyc(p + 1);
  endtask

  logic [4:0] ap;
  logic [4:0] ep;
  // Per-cycle comparison of every output against the expectation tables.
  always @(negedge clkIn) begin
    if (chk_en) begin
      ap = {iDataValid, memDataValid, acceptWrite, mutableMemInValid, mutableWriteSuc};
      ep = exp_pulse.exists(cyc) ? exp_pulse[cyc] : 5'b00000;
      check("pulses", ap, ep);
      check("memWr", memWr, exp_wr.exists(cyc) ? exp_wr[cyc] : 1'b0);
      if (exp_a.exists(cyc)) check("memA", memA, exp_a[cyc]);
      if (exp_wr.exists(cyc) && exp_wr[cyc]) check("memOut", memOut, exp_out[cyc]);
      if (exp_data.exists(cyc)) begin
        if (ep[4]) check("iDataOut", iDataOut, exp_data[cyc]);
        if (ep[3]) check("memDataOut", memDataOut, exp_data[cyc]);
        if (ep[1]) check("ioReadData", mutableMemDataOut, exp_data[cyc]);
      end
      if (exp_maddr.exists(cyc)) check("memAddr", memAddr, exp_maddr[cyc]);
      if (lit_pulse.exists(cyc)) check("lit_pulse", ap, lit_pulse[cyc]);
      if (lit_data.exists(cyc)) check("lit_data", (ap[1] ? {96'd0, mutableMemDataOut} : iDataOut), lit_data[cyc]);
      if (lit_a.exists(cyc)) check("lit_memA", memA, lit_a[cyc]);
    end
  end

  initial begin
    int g;
    int p;
    logic [127:0] line;

    // Reset state
    step(); step();
    @(negedge clkIn);
    check("rst_memA", memA, 32'd0);
    check("rst_memWr", memWr, 1'b0);
    check("rst_pulses", {iDataValid, memDataValid, acceptWrite, mutableMemInValid, mutableWriteSuc}, 5'd0);
    check("rst_iDataOut", iDataOut, 128'd0);
    check("rst_ioData", mutableMemDataOut, 32'd0);
    step();
    resetIn = 1'b1;
    chk_en = 1'b1;
    step();

    // ICache line 0x100
    g = cyc;
    iMiss = 1'b1; iMissAddr = 28'h100;
    plan_line_read(g, 32'h1000, 1'b1);
    lit_a[g+1] = 32'h1000;
    lit_a[g+16] = 32'h100F;
    lit_pulse[g+18] = 5'b10000;
    lit_data[g+18] = 128'h0F0E0D0C0B0A09080706050403020100;
    step();
    iMiss = 1'b0;
    wait_cyc(g + 19);

    // DCache write-back 0x200, all 0xAA
    g = cyc;
    dMiss = 1'b1; dReadWrite = 1'b0; dMissAddr = 28'h200; dWriteData = {16{8'hAA}};
    plan_line_write(g, 32'h2000, {16{8'hAA}}, 16, 1'b1);
    lit_a[g+1] = 32'h2000;
    lit_pulse[g+17] = 5'b00100;
    step();
    dMiss = 1'b0; dWriteData = '0;
    wait_cyc(g + 18);

    // IO word write with buffer-full in burst cycles 1..3
    lit_pulse[cyc+8] = 5'b00001;
    do_io(1'b0, 2'b11, 32'h30000, 32'hDEADBEEF, 32'b1110);
    // IO word read back
    lit_pulse[cyc+6] = 5'b00010;
    lit_data[cyc+6] = 128'hDEADBEEF;
    do_io(1'b1, 2'b11, 32'h30000, 32'd0, 0);
    // Half read, byte write, byte read
    lit_data[cyc+4] = 128'h0000DEAD;
    do_io(1'b1, 2'b10, 32'h30002, 32'd0, 0);
    lit_pulse[cyc+2] = 5'b00001;
    do_io(1'b0, 2'b01, 32'h30001, 32'hFFFFFF55, 0);
    lit_data[cyc+3] = 128'h55;
    do_io(1'b1, 2'b01, 32'h30001, 32'd0, 0);

    // ICache and DCache read requested together
    g = cyc;
    iMiss = 1'b1; iMissAddr = 28'h701;
    dMiss = 1'b1; dReadWrite = 1'b1; dMissAddr = 28'h200;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
    lit_pulse[g+18] = 5'b10000;
    plan_line_read(g, 32'h7010, 1'b1);
    step();
    iMiss = 1'b0;
    wait_cyc(g + 19);
    plan_line_read(g + 19, 32'h2000, 1'b0);
    step();
    dMiss = 1'b0;
`else
    lit_pulse[g+18] = 5'b01000;
    plan_line_read(g, 32'h2000, 1'b0);
    step();
    dMiss = 1'b0;
    wait_cyc(g + 19);
    plan_line_read(g + 19, 32'h7010, 1'b1);
    step();
    iMiss = 1'b0;
`endif
    wait_cyc(g + 38);

    // Flush during ICache read at burst cycle 8
    g = cyc;
    iMiss = 1'b1; iMissAddr = 28'h600;
    for (int k = 0; k <= 8; k++) begin
      exp_a[g+1+k] = 32'h6000 + k;
      exp_wr[g+1+k] = 1'b0;
    end
    exp_a[g+10] = 32'd0;
    step();
    iMiss = 1'b0;
    wait_cyc(g + 9);
    clearIn = 1'b1;
    step();
    clearIn = 1'b0;
    wait_cyc(g + 21);

    // Flush during write-back is ignored
    g = cyc;
    line = 128'h0123456789ABCDEFFEDCBA9876543210;
    dMiss = 1'b1; dReadWrite = 1'b0; dMissAddr = 28'h900; dWriteData = line;
    plan_line_write(g, 32'h9000, line, 16, 1'b1);
    lit_pulse[g+17] = 5'b00100;
    step();
    dMiss = 1'b0;
    wait_cyc(g + 9);
    clearIn = 1'b1;
    step();
    clearIn = 1'b0;
    wait_cyc(g + 18);

    // Flush in the completion cycle of an IO read
    g = cyc;
    ioValid = 1'b1; ioReadWrite = 1'b1; ioType = 2'b01; ioAddr = 32'h30001;
    plan_io(g, 1'b1, 2'b01, 32'h30001, 32'd0, 0, p);
    exp_pulse.delete(p);
    exp_data.delete(p);
    step();
    ioValid = 1'b0;
    wait_cyc(p);
    clearIn = 1'b1;
    step();
    clearIn = 1'b0;
    step();

    // Reset in burst cycle 5 of a write-back, then a fresh IO write
    g = cyc;
    dMiss = 1'b1; dReadWrite = 1'b0; dMissAddr = 28'hA00; dWriteData = {16{8'h3C}};
    plan_line_write(g, 32'hA000, {16{8'h3C}}, 5, 1'b0);
    exp_a[g+6] = 32'd0;
    exp_a[g+7] = 32'd0;
    step();
    dMiss = 1'b0;
    wait_cyc(g + 6);
    resetIn = 1'b0;
    step();
    resetIn = 1'b1;
    lit_pulse[cyc+2] = 5'b00001;
    do_io(1'b0, 2'b01, 32'h30010, 32'h000000C3, 0);

    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
